// File: rtl/tiger_defines.sv
// Shared definitions for the tiger fetch path: controller state encodings,
// default boot address, and the word-alignment helper.
package tiger_defines;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_FULL  = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_e;

    localparam logic [31:0] TIGER_BOOT_ADDR = 32'h0000_0000;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/tiger_fetch_ctrl.sv
// Single-entry instruction fetch controller: issues one memory request at a time,
// buffers the returned word for decode, and handles flush redirects mid-request.
module tiger_fetch_ctrl
    import tiger_defines::*;
#(
    parameter logic [31:0] BOOT_ADDR   = TIGER_BOOT_ADDR,
    parameter logic [31:0] COUNT_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_in,
    input  logic        flush,
    input  logic [31:0] flush_addr,
    input  logic        pipe_stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc,
    output logic        fetch_stall,
    output logic [31:0] fetch_count
);

    fetch_state_e state_q, state_d;
    logic [31:0]  addr_q, addr_d;
    logic [31:0]  flush_lat_q, flush_lat_d;
    logic         valid_q, valid_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  count_q, count_d;
    logic         consume;

    assign consume = valid_q && !pipe_stall && !flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= align_word(BOOT_ADDR);
            flush_lat_q <= 32'h0;
            valid_q     <= 1'b0;
            instr_q     <= 32'h0;
            pc_q        <= 32'h0;
            count_q     <= COUNT_RESET;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            flush_lat_q <= flush_lat_d;
            valid_q     <= valid_d;
            instr_q     <= instr_d;
            pc_q        <= pc_d;
            count_q     <= count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        flush_lat_d = flush_lat_q;
        valid_d     = valid_q;
        instr_d     = instr_q;
        pc_d        = pc_q;
        count_d     = count_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
                addr_d  = flush ? align_word(flush_addr) : align_word(BOOT_ADDR);
            end
            ST_REQ: begin
                if (imem_ack) begin
                    if (flush) begin
                        addr_d = align_word(flush_addr);
                    end else begin
                        state_d = ST_FULL;
                        instr_d = imem_rdata;
                        pc_d    = addr_q;
                        valid_d = 1'b1;
                    end
                end else if (flush) begin
                    // Request stays outstanding; redirect once it completes.
                    flush_lat_d = align_word(flush_addr);
                    state_d     = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (flush) begin
                    flush_lat_d = align_word(flush_addr);
                end
                if (imem_ack) begin
                    state_d = ST_REQ;
                    addr_d  = flush ? align_word(flush_addr) : flush_lat_q;
                end
            end
            ST_FULL: begin
                if (flush) begin
                    valid_d = 1'b0;
                    state_d = ST_REQ;
                    addr_d  = align_word(flush_addr);
                end else if (consume) begin
                    valid_d = 1'b0;
                    state_d = ST_REQ;
                    addr_d  = align_word(pc_in);
                    count_d = count_q + 32'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign imem_req    = (state_q == ST_REQ) || (state_q == ST_DRAIN);
    assign imem_addr   = addr_q;
    assign instr_valid = valid_q;
    assign instr_out   = instr_q;
    assign instr_pc    = pc_q;
    assign fetch_stall = !valid_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_tiger_fetch_ctrl.sv
// Directed bench for tiger_fetch_ctrl; a second instance with a preloaded
// counter exercises the fetch_count wrap.
module tb_tiger_fetch_ctrl;

    localparam logic [31:0] TB_BOOT = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc_in = 32'h0;
    logic        flush = 1'b0;
    logic [31:0] flush_addr = 32'h0;
    logic        pipe_stall = 1'b0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;

    logic        imem_req, instr_valid, fetch_stall;
    logic [31:0] imem_addr, instr_out, instr_pc, fetch_count;
    logic        w_req, w_valid, w_stall;
    logic [31:0] w_addr, w_out, w_pc, w_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    tiger_fetch_ctrl #(.BOOT_ADDR(TB_BOOT)) dut (
        .clk(clk), .reset(reset), .pc_in(pc_in), .flush(flush), .flush_addr(flush_addr),
        .pipe_stall(pipe_stall), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
        .instr_out(instr_out), .instr_pc(instr_pc), .fetch_stall(fetch_stall),
        .fetch_count(fetch_count)
    );

    tiger_fetch_ctrl #(.BOOT_ADDR(TB_BOOT), .COUNT_RESET(32'hFFFF_FFFF)) dut_w (
        .clk(clk), .reset(reset), .pc_in(pc_in), .flush(flush), .flush_addr(flush_addr),
        .pipe_stall(pipe_stall), .imem_req(w_req), .imem_addr(w_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_valid(w_valid),
        .instr_out(w_out), .instr_pc(w_pc), .fetch_stall(w_stall),
        .fetch_count(w_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hA0A0_0001;
        tick(); tick();
        n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b want 0", imem_req); end
        n_cmp++; if (imem_addr !== TB_BOOT) begin n_err++; $display("FAIL rst_addr: got %h want %h", imem_addr, TB_BOOT); end
        n_cmp++; if (instr_valid !== 1'b0 || fetch_stall !== 1'b1) begin n_err++; $display("FAIL rst_valid: got %b/%b want 0/1", instr_valid, fetch_stall); end
        n_cmp++; if (instr_out !== 32'h0 || instr_pc !== 32'h0) begin n_err++; $display("FAIL rst_instr: got %h/%h want 0/0", instr_out, instr_pc); end
        n_cmp++; if (fetch_count !== 32'h0) begin n_err++; $display("FAIL rst_count: got %h want 0", fetch_count); end
        $display("txn reset: req=%b addr=%h valid=%b count=%0d", imem_req, imem_addr, instr_valid, fetch_count);
    endtask

    task automatic test_boot_ack_high();
        pc_in = 32'h0000_2000; pipe_stall = 1'b0;
        reset = 1'b0;
        tick();
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== TB_BOOT) begin n_err++; $display("FAIL boot_c1: got req=%b addr=%h want 1/%h", imem_req, imem_addr, TB_BOOT); end
        tick();
        n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== TB_BOOT || instr_out !== 32'hA0A0_0001) begin n_err++; $display("FAIL boot_c2: got v=%b pc=%h out=%h want 1/%h/a0a00001", instr_valid, instr_pc, instr_out, TB_BOOT); end
        n_cmp++; if (imem_req !== 1'b0 || fetch_stall !== 1'b0) begin n_err++; $display("FAIL boot_c2_req: got req=%b stall=%b want 0/0", imem_req, fetch_stall); end
        tick();
        imem_ack = 1'b0;
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_2000 || instr_valid !== 1'b0) begin n_err++; $display("FAIL boot_next: got req=%b addr=%h v=%b want 1/00002000/0", imem_req, imem_addr, instr_valid); end
        n_cmp++; if (fetch_count !== 32'd1) begin n_err++; $display("FAIL boot_count: got %0d want 1", fetch_count); end
        $display("txn boot: pc=%h next_addr=%h count=%0d", instr_pc, imem_addr, fetch_count);
    endtask

    task automatic test_stall();
        imem_ack = 1'b1; imem_rdata = 32'hBBBB_0002; pipe_stall = 1'b1; pc_in = 32'h0000_3000;
        tick();
        imem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (instr_valid !== 1'b1 || instr_out !== 32'hBBBB_0002 || instr_pc !== 32'h0000_2000 || imem_req !== 1'b0) begin
                n_err++; $display("FAIL stall_hold[%0d]: got v=%b out=%h pc=%h req=%b want 1/bbbb0002/00002000/0", i, instr_valid, instr_out, instr_pc, imem_req);
            end
            if (i < 4) tick();
        end
        pipe_stall = 1'b0; imem_ack = 1'b0;
        tick();
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_3000 || fetch_count !== 32'd2) begin n_err++; $display("FAIL stall_release: got req=%b addr=%h count=%0d want 1/00003000/2", imem_req, imem_addr, fetch_count); end
        $display("txn stall: released addr=%h count=%0d", imem_addr, fetch_count);
    endtask

    task automatic test_flush_drain();
        tick();
        flush = 1'b1; flush_addr = 32'h0000_0180;
        tick();
        flush = 1'b0; flush_addr = 32'hFFFF_FFF0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h0000_3000 || instr_valid !== 1'b0) begin
                n_err++; $display("FAIL drain_hold[%0d]: got req=%b addr=%h v=%b want 1/00003000/0", i, imem_req, imem_addr, instr_valid);
            end
            if (i < 2) tick();
        end
        imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        tick();
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0180 || instr_valid !== 1'b0) begin n_err++; $display("FAIL drain_redirect: got req=%b addr=%h v=%b want 1/00000180/0", imem_req, imem_addr, instr_valid); end
        imem_rdata = 32'h1111_0180;
        tick();
        imem_ack = 1'b0;
        n_cmp++; if (instr_valid !== 1'b1 || instr_out !== 32'h1111_0180 || instr_pc !== 32'h0000_0180) begin n_err++; $display("FAIL drain_fill: got v=%b out=%h pc=%h want 1/11110180/00000180", instr_valid, instr_out, instr_pc); end
        pc_in = 32'h0000_4000;
        tick();
        n_cmp++; if (imem_addr !== 32'h0000_4000 || fetch_count !== 32'd3) begin n_err++; $display("FAIL drain_consume: got addr=%h count=%0d want 00004000/3", imem_addr, fetch_count); end
        $display("txn flush_drain: pc=00000180 next_addr=%h count=%0d", imem_addr, fetch_count);
    endtask

    task automatic test_double_flush();
        flush = 1'b1; flush_addr = 32'h0000_0100;
        tick();
        flush_addr = 32'h0000_0200;
        tick();
        flush = 1'b0;
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_4000) begin n_err++; $display("FAIL dbl_hold: got req=%b addr=%h want 1/00004000", imem_req, imem_addr); end
        imem_ack = 1'b1; imem_rdata = 32'h2222_0200;
        tick();
        n_cmp++; if (imem_addr !== 32'h0000_0200 || instr_valid !== 1'b0) begin n_err++; $display("FAIL dbl_redirect: got addr=%h v=%b want 00000200/0", imem_addr, instr_valid); end
        pipe_stall = 1'b1;
        tick();
        imem_ack = 1'b0;
        n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0000_0200 || instr_out !== 32'h2222_0200) begin n_err++; $display("FAIL dbl_fill: got v=%b pc=%h out=%h want 1/00000200/22220200", instr_valid, instr_pc, instr_out); end
        $display("txn double_flush: pc=%h", instr_pc);
    endtask

    task automatic test_flush_consume();
        pipe_stall = 1'b0; flush = 1'b1; flush_addr = 32'h0000_0300; pc_in = 32'h0000_5000;
        tick();
        n_cmp++; if (instr_valid !== 1'b0 || imem_addr !== 32'h0000_0300 || fetch_count !== 32'd3) begin n_err++; $display("FAIL flush_consume: got v=%b addr=%h count=%0d want 0/00000300/3", instr_valid, imem_addr, fetch_count); end
        imem_ack = 1'b1; flush_addr = 32'h0000_0340; imem_rdata = 32'h3333_0300;
        tick();
        flush = 1'b0;
        n_cmp++; if (instr_valid !== 1'b0 || imem_addr !== 32'h0000_0340 || imem_req !== 1'b1) begin n_err++; $display("FAIL ack_flush: got v=%b addr=%h req=%b want 0/00000340/1", instr_valid, imem_addr, imem_req); end
        imem_rdata = 32'h4444_0340; pipe_stall = 1'b1;
        tick();
        imem_ack = 1'b0; pipe_stall = 1'b0; pc_in = 32'h0000_5003;
        n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0000_0340) begin n_err++; $display("FAIL ack_flush_fill: got v=%b pc=%h want 1/00000340", instr_valid, instr_pc); end
        tick();
        n_cmp++; if (imem_addr !== 32'h0000_5000 || fetch_count !== 32'd4) begin n_err++; $display("FAIL align: got addr=%h count=%0d want 00005000/4", imem_addr, fetch_count); end
        $display("txn flush_consume: addr=%h count=%0d", imem_addr, fetch_count);
    endtask

    task automatic test_mid_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0; imem_ack = 1'b1; pipe_stall = 1'b1;
        n_cmp++; if (imem_req !== 1'b0 || imem_addr !== TB_BOOT || fetch_count !== 32'd0) begin n_err++; $display("FAIL midrst: got req=%b addr=%h count=%0d want 0/%h/0", imem_req, imem_addr, fetch_count, TB_BOOT); end
        tick();
        imem_ack = 1'b0;
        n_cmp++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== TB_BOOT) begin n_err++; $display("FAIL midrst_ack: got v=%b req=%b addr=%h want 0/1/%h", instr_valid, imem_req, imem_addr, TB_BOOT); end
        $display("txn mid_reset: req=%b addr=%h", imem_req, imem_addr);
    endtask

    task automatic test_wrap();
        n_cmp++; if (w_count !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL wrap_start: got %h want ffffffff", w_count); end
        imem_ack = 1'b1; imem_rdata = 32'h5555_1000;
        tick();
        imem_ack = 1'b0; pipe_stall = 1'b0; pc_in = 32'h0000_6000;
        tick();
        n_cmp++; if (w_count !== 32'h0 || w_addr !== 32'h0000_6000) begin n_err++; $display("FAIL wrap: got count=%h addr=%h want 0/00006000", w_count, w_addr); end
        n_cmp++; if (fetch_count !== 32'd1) begin n_err++; $display("FAIL wrap_ref: got %0d want 1", fetch_count); end
        $display("txn wrap: count=%h", w_count);
    endtask

    initial begin
        test_reset();
        test_boot_ack_high();
        test_stall();
        test_flush_drain();
        test_double_flush();
        test_flush_consume();
        test_mid_reset();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
